serial_adder: RTL
=================

# serial_adder

Parametrised bit-serial adder, the sequential successor to the half-adder primitive. It accepts two WIDTH-bit operands through a valid/ready handshake and adds them one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop. It returns sum, carry-out and signed overflow through a second valid/ready handshake. It is the area-minimal arithmetic unit for datapaths where latency is cheap and gates are not.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  operands a/b (and sub) are valid.
- in_ready  output  1  block can accept operands (state IDLE).
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- sub  input  1  present only with SERIAL_ADDER_SUB_EN; 1 = compute a − b.
- out_valid  output  1  result valid (state DONE).
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry out of the MSB (for subtract: 1 = no borrow).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid at a rising edge: latch a and b into shift registers, load carry with carry-in (0, or sub when SUB_EN), clear the bit counter, go to RUN.
- RUN:
  - Each edge computes s = a0 ^ b0' ^ c and c' = majority(a0, b0', c), where b0' is b0, or ~b0 when subtracting.
  - s shifts into the sum register from the MSB side. The a and b registers shift right. Carry updates.
  - The counter ($clog2(WIDTH) bits) increments.
  - On the edge where counter == WIDTH−1: capture cout=c', ovf=c ^ c', go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_ready at an edge: go to IDLE. sum, cout and ovf keep their values until the next operand is accepted.
- in_valid is ignored in RUN and DONE because in_ready=0. Operands must not be assumed held after acceptance.
- Reset (rst_n=0 at any edge, including mid-RUN or in DONE):
  - State → IDLE; sum, cout, ovf, counter and carry → 0.
  - After reset: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - Any in-flight operation is discarded with no output.
- Arithmetic is modulo 2^WIDTH. cout and ovf are the only out-of-range indicators.

## Timing
- Accept at edge T0 (IDLE, in_valid=1).
- RUN occupies edges T0+1 … T0+WIDTH. out_valid rises after edge T0+WIDTH, so latency is WIDTH cycles.
- With out_ready held high: DONE lasts one cycle, IDLE is re-entered after edge T0+WIDTH+1, and the next accept is possible at edge T0+WIDTH+2. Peak throughput is one operation per WIDTH+2 cycles.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from any input to any output.
- Backpressure: DONE persists indefinitely while out_ready=0, with outputs unchanged.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists and is sampled with the operands at acceptance.
  - sub=1 inverts b bits in the datapath and sets carry-in=1, giving a − b.
  - cout=1 means no borrow; ovf is signed subtraction overflow.
- SERIAL_ADDER_SUB_EN undefined:
  - No sub port; carry-in is always 0; add only.
  - No inverter logic is synthesised.

## Test plan
- Reset, then a=0x00, b=0x00 (WIDTH=8) → out_valid exactly 8 cycles after accept; sum=0x00, cout=0, ovf=0; in_ready low during RUN and DONE.
- a=0xFF, b=0x01 → sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1. Both issued back-to-back with out_ready=1, and the second accept occurs exactly WIDTH+2 cycles after the first.
- Hold out_ready=0 for 5 cycles in DONE after a=0x12, b=0x34 while driving in_valid=1 with a=0xAA → sum stays 0x46; 0xAA is not accepted until after the result is taken.
- Assert rst_n=0 for one edge after 3 RUN cycles of a=0x0F, b=0x01 → next cycle state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0; a fresh a=0x03, b=0x04 gives sum=0x07.
- SERIAL_ADDER_SUB_EN, sub=1: a=0x05, b=0x07 → sum=0xFE, cout=0; a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1.
- WIDTH=2 and WIDTH=13 randomised 200 operations each against a reference model → all sum, cout and ovf values match.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop add two WIDTH-bit operands LSB first.
// Latency WIDTH cycles from accept to out_valid; one operation per WIDTH+2 cycles at best.
// Backpressure: DONE holds sum/cout/ovf stable while out_ready=0; in_ready is low outside IDLE.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the sub port).
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             accept, last;
   logic             b_bit, s_bit, c_nxt, cin;

`ifdef SERIAL_ADDER_SUB_EN
   logic sub_r;
   // Subtract is a + ~b + 1: invert the serial b bit and seed the carry with 1.
   assign b_bit = b_sh[0] ^ sub_r;
   assign cin   = sub;
`else
   assign b_bit = b_sh[0];
   assign cin   = 1'b0;
`endif

   // Single full-adder cell fed from the LSBs of the shift registers.
   assign s_bit = a_sh[0] ^ b_bit ^ carry;
   assign c_nxt = (a_sh[0] & b_bit) | (a_sh[0] & carry) | (b_bit & carry);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake decode; in_ready/out_valid depend on state only.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cnt == LAST) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: load operands on accept, shift one bit per RUN cycle, capture flags on the last bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         cnt   <= '0;
         carry <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
         sub_r <= 1'b0;
`endif
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= b;
         carry <= cin;
         cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
         sub_r <= sub;
`endif
      end else if (state == RUN) begin
         sum   <= {s_bit, sum[WIDTH-1:1]};
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         carry <= c_nxt;
         cnt   <= cnt + CW'(1);
         if (last) begin
            cout <= c_nxt;
            ovf  <= carry ^ c_nxt;
         end
      end
   end

endmodule
